// File: rtl/ins_controller.sv
`default_nettype none
// ============================================================================
//  Module   : ins_controller
//  Purpose  : Multi-cycle control FSM for the 8-bit core. Sequences
//             fetch / decode / execute / memory / writeback, drives the PC,
//             IR, register file, ALU and a req/ack memory port, counts
//             retired instructions and latches a fault on memory timeout.
//  Ports    : clk, rst (async, active-high)
//             start                  - leave IDLE
//             opcode, rt_rd, rs      - decoder fields
//             zero                   - datapath zero flag (sampled in EXEC)
//             mem_ack / mem_req,
//             mem_we, addr_sel       - shared memory port
//             ir_load, pc_load,
//             pc_src, reg_we,
//             reg_wsel, alu_op,
//             wb_sel                 - datapath controls
//             halted, fault          - stop status
//             instr_count            - saturating retired-instruction count
//             state_dbg              - current state encoding
//  Revision : 1.0 - initial release
// ============================================================================
module ins_controller #(
   parameter int TIMEOUT = 15,
   parameter int CNT_W   = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [2:0]       opcode,
   input  logic             rt_rd,
   input  logic             rs,
   input  logic             zero,
   input  logic             mem_ack,
   output logic             mem_req,
   output logic             mem_we,
   output logic             addr_sel,
   output logic             ir_load,
   output logic             pc_load,
   output logic             pc_src,
   output logic             reg_we,
   output logic             reg_wsel,
   output logic             alu_op,
   output logic [1:0]       wb_sel,
   output logic             halted,
   output logic             fault,
   output logic [CNT_W-1:0] instr_count,
   output logic [2:0]       state_dbg
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_FETCH  = 3'd1,
      S_DECODE = 3'd2,
      S_EXEC   = 3'd3,
      S_MEM    = 3'd4,
      S_WB     = 3'd5,
      S_HALT   = 3'd6
   } state_t;

   localparam logic [2:0] c_op_add  = 3'b000;
   localparam logic [2:0] c_op_sub  = 3'b001;
   localparam logic [2:0] c_op_ldi  = 3'b010;
   localparam logic [2:0] c_op_ld   = 3'b011;
   localparam logic [2:0] c_op_st   = 3'b100;
   localparam logic [2:0] c_op_beqz = 3'b101;
   localparam logic [2:0] c_op_jmp  = 3'b110;

   localparam logic [7:0]       c_tmo_max = 8'(TIMEOUT);
   localparam logic [CNT_W-1:0] c_cnt_max = '1;

   state_t           state_q, state_d;
   logic [7:0]       tmo_q, tmo_d;
   logic             fault_q, fault_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             w_retire_halt;

   // rs only steers the datapath address mux (via addr_sel); the FSM itself
   // never needs its value.
   logic w_unused_rs;
   assign w_unused_rs = rs;

   always_comb begin
      state_d       = state_q;
      tmo_d         = tmo_q;
      fault_d       = fault_q;
      w_retire_halt = 1'b0;
      mem_req       = 1'b0;
      mem_we        = 1'b0;
      addr_sel      = 1'b0;
      ir_load       = 1'b0;
      pc_load       = 1'b0;
      pc_src        = 1'b0;
      reg_we        = 1'b0;
      reg_wsel      = 1'b0;
      alu_op        = 1'b0;
      wb_sel        = 2'b00;
      halted        = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = S_FETCH;
               tmo_d   = 8'd0;
            end
         end

         S_FETCH: begin
            mem_req = 1'b1;
            // An ack arriving on the final allowed cycle still completes.
            if (mem_ack) begin
               ir_load = 1'b1;
               state_d = S_DECODE;
            end else if (tmo_q == c_tmo_max) begin
               state_d = S_HALT;
               fault_d = 1'b1;
            end else begin
               tmo_d = tmo_q + 8'd1;
            end
         end

         S_DECODE: begin
            if (opcode == 3'b111) begin
               state_d       = S_HALT;
               w_retire_halt = 1'b1;
            end else begin
               state_d = S_EXEC;
            end
         end

         S_EXEC: begin
            case (opcode)
               c_op_add, c_op_sub: begin
                  alu_op  = (opcode == c_op_sub);
                  state_d = S_WB;
               end
               c_op_ldi: state_d = S_WB;
               c_op_ld, c_op_st: begin
                  state_d = S_MEM;
                  tmo_d   = 8'd0;
               end
               c_op_beqz: begin
                  pc_load = 1'b1;
                  pc_src  = zero;
                  state_d = S_FETCH;
                  tmo_d   = 8'd0;
               end
               c_op_jmp: begin
                  pc_load = 1'b1;
                  pc_src  = 1'b1;
                  state_d = S_FETCH;
                  tmo_d   = 8'd0;
               end
               // HALT is diverted in DECODE; reaching here means the
               // decoder fields changed mid-instruction, so stop safely.
               default: state_d = S_HALT;
            endcase
         end

         S_MEM: begin
            mem_req  = 1'b1;
            addr_sel = 1'b1;
            mem_we   = (opcode == c_op_st);
            if (mem_ack) begin
               if (opcode == c_op_st) begin
                  pc_load = 1'b1;
                  state_d = S_FETCH;
                  tmo_d   = 8'd0;
               end else begin
                  state_d = S_WB;
               end
            end else if (tmo_q == c_tmo_max) begin
               state_d = S_HALT;
               fault_d = 1'b1;
            end else begin
               tmo_d = tmo_q + 8'd1;
            end
         end

         S_WB: begin
            reg_we   = 1'b1;
            reg_wsel = rt_rd;
            pc_load  = 1'b1;
            alu_op   = (opcode == c_op_sub);
            if (opcode == c_op_ldi)
               wb_sel = 2'b01;
            else if (opcode == c_op_ld)
               wb_sel = 2'b10;
            else
               wb_sel = 2'b00;
            state_d = S_FETCH;
            tmo_d   = 8'd0;
         end

         S_HALT: begin
            halted = 1'b1;
         end

         // Unused encoding 7 falls back to IDLE.
         default: state_d = S_IDLE;
      endcase

      cnt_d = cnt_q;
      if ((pc_load || w_retire_halt) && (cnt_q != c_cnt_max))
         cnt_d = cnt_q + 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         tmo_q   <= 8'd0;
         fault_q <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         tmo_q   <= tmo_d;
         fault_q <= fault_d;
         cnt_q   <= cnt_d;
      end
   end

   assign fault       = fault_q;
   assign instr_count = cnt_q;
   assign state_dbg   = state_q;

endmodule
`default_nettype wire

// File: tb/tb_ins_controller.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ins_controller
//  Purpose  : Directed self-checking bench for ins_controller. A second
//             instance with CNT_W=2 shares all inputs to observe counter
//             saturation.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ins_controller;

   logic       clk = 1'b0;
   logic       rst, start, zero, mem_ack, rt_rd, rs;
   logic [2:0] opcode;

   logic        mem_req, mem_we, addr_sel, ir_load, pc_load, pc_src;
   logic        reg_we, reg_wsel, alu_op, halted, fault;
   logic [1:0]  wb_sel;
   logic [15:0] instr_count;
   logic [2:0]  state_dbg;

   logic        b_mem_req, b_mem_we, b_addr_sel, b_ir_load, b_pc_load, b_pc_src;
   logic        b_reg_we, b_reg_wsel, b_alu_op, b_halted, b_fault;
   logic [1:0]  b_wb_sel;
   logic [1:0]  b_instr_count;
   logic [2:0]  b_state_dbg;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   ins_controller #(.TIMEOUT(15), .CNT_W(16)) dut (
      .clk(clk), .rst(rst), .start(start), .opcode(opcode), .rt_rd(rt_rd),
      .rs(rs), .zero(zero), .mem_ack(mem_ack), .mem_req(mem_req),
      .mem_we(mem_we), .addr_sel(addr_sel), .ir_load(ir_load),
      .pc_load(pc_load), .pc_src(pc_src), .reg_we(reg_we),
      .reg_wsel(reg_wsel), .alu_op(alu_op), .wb_sel(wb_sel),
      .halted(halted), .fault(fault), .instr_count(instr_count),
      .state_dbg(state_dbg)
   );

   ins_controller #(.TIMEOUT(15), .CNT_W(2)) dut2 (
      .clk(clk), .rst(rst), .start(start), .opcode(opcode), .rt_rd(rt_rd),
      .rs(rs), .zero(zero), .mem_ack(mem_ack), .mem_req(b_mem_req),
      .mem_we(b_mem_we), .addr_sel(b_addr_sel), .ir_load(b_ir_load),
      .pc_load(b_pc_load), .pc_src(b_pc_src), .reg_we(b_reg_we),
      .reg_wsel(b_reg_wsel), .alu_op(b_alu_op), .wb_sel(b_wb_sel),
      .halted(b_halted), .fault(b_fault), .instr_count(b_instr_count),
      .state_dbg(b_state_dbg)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Advance to just after the next rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // From a FETCH cycle: ack immediately, land in DECODE.
   task automatic fetch_now();
      mem_ack = 1'b1;
      tick();
      mem_ack = 1'b0;
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; opcode = 3'd0; rt_rd = 1'b0; rs = 1'b0;
      zero = 1'b0; mem_ack = 1'b0;
      tick(); tick();
      chk("reset_state", state_dbg, 0);
      chk("reset_count", instr_count, 0);
      chk("reset_halted", halted, 0);
      chk("reset_fault", fault, 0);
      chk("reset_mem_req", mem_req, 0);

      // Async reset pulse while FETCH is requesting
      rst = 1'b0; start = 1'b1;
      tick(); start = 1'b0;
      chk("t1_fetch_state", state_dbg, 1);
      chk("t1_fetch_req", mem_req, 1);
      rst = 1'b1; #1;
      chk("t1_rst_req", mem_req, 0);
      chk("t1_rst_state", state_dbg, 0);
      chk("t1_rst_count", instr_count, 0);
      rst = 1'b0; #1;
      start = 1'b1;
      tick(); start = 1'b0;
      chk("t1_restart", state_dbg, 1);

      // ADD (IR 0x18), zero-wait fetch
      opcode = 3'b000; rt_rd = 1'b1; rs = 1'b1; mem_ack = 1'b1; #1;
      chk("add_ir_load", ir_load, 1);
      chk("add_addr_sel", addr_sel, 0);
      chk("add_mem_we", mem_we, 0);
      tick(); mem_ack = 1'b0;
      chk("add_decode", state_dbg, 2);
      tick();
      chk("add_exec", state_dbg, 3);
      chk("add_alu_op", alu_op, 0);
      tick();
      chk("add_wb", state_dbg, 5);
      chk("add_wb_ctl", {reg_we, reg_wsel, wb_sel, pc_load, pc_src}, 6'b11_00_10);
      tick();
      chk("add_back_fetch", state_dbg, 1);
      chk("add_count", instr_count, 1);

      // LD with 3 wait cycles in MEM
      opcode = 3'b011; rt_rd = 1'b0;
      fetch_now();
      tick(); tick();
      for (int i = 0; i < 3; i++) begin
         chk("ld_mem_state", state_dbg, 4);
         chk("ld_mem_ctl", {mem_req, addr_sel, mem_we}, 3'b110);
         tick();
      end
      mem_ack = 1'b1; #1;
      chk("ld_mem_last", {state_dbg, mem_req, addr_sel, mem_we}, {3'd4, 3'b110});
      chk("ld_no_ir_load", ir_load, 0);
      tick(); mem_ack = 1'b0;
      chk("ld_wb", state_dbg, 5);
      chk("ld_wb_sel", wb_sel, 2);
      chk("ld_wb_we", {reg_we, reg_wsel}, 2'b10);
      tick();
      chk("ld_count", instr_count, 2);

      // ST, zero-wait
      opcode = 3'b100;
      fetch_now();
      tick(); tick();
      mem_ack = 1'b1; #1;
      chk("st_mem_ctl", {mem_req, addr_sel, mem_we, pc_load, pc_src, reg_we}, 6'b111100);
      tick(); mem_ack = 1'b0;
      chk("st_back_fetch", state_dbg, 1);
      chk("st_count", instr_count, 3);

      // BEQZ (0xA7), zero=1 then zero=0
      opcode = 3'b101; rt_rd = 1'b0; rs = 1'b0; zero = 1'b1;
      fetch_now();
      tick();
      chk("beqz1_exec", {state_dbg, pc_load, pc_src, reg_we}, {3'd3, 3'b110});
      tick();
      chk("beqz1_fetch", state_dbg, 1);
      chk("beqz1_count", instr_count, 4);
      zero = 1'b0;
      fetch_now();
      tick();
      chk("beqz0_exec", {state_dbg, pc_load, pc_src, reg_we}, {3'd3, 3'b100});
      tick();
      chk("beqz0_count", instr_count, 5);
      chk("sat_count_w2", b_instr_count, 3);

      // SUB: alu_op held from EXEC through WB
      opcode = 3'b001; rt_rd = 1'b0;
      fetch_now();
      tick();
      chk("sub_exec_alu", alu_op, 1);
      tick();
      chk("sub_wb", {state_dbg, alu_op, wb_sel, reg_we}, {3'd5, 1'b1, 2'b00, 1'b1});
      tick();
      chk("sub_count", instr_count, 6);

      // LDI
      opcode = 3'b010; rt_rd = 1'b1;
      fetch_now();
      tick();
      chk("ldi_exec", {state_dbg, alu_op}, {3'd3, 1'b0});
      tick();
      chk("ldi_wb", {wb_sel, reg_we, reg_wsel}, 4'b0111);
      tick();
      chk("ldi_count", instr_count, 7);

      // JMP with ack on the last permitted FETCH cycle (16th)
      opcode = 3'b110;
      for (int i = 0; i < 15; i++) tick();
      mem_ack = 1'b1; #1;
      chk("tmo_edge_state", state_dbg, 1);
      chk("tmo_edge_ir_load", ir_load, 1);
      tick(); mem_ack = 1'b0;
      chk("tmo_edge_decode", state_dbg, 2);
      chk("tmo_edge_no_fault", fault, 0);
      tick();
      chk("jmp_exec", {pc_load, pc_src}, 2'b11);
      tick();
      chk("jmp_count", instr_count, 8);

      // HALT opcode (0xE0)
      opcode = 3'b111; rt_rd = 1'b0;
      fetch_now();
      chk("halt_decode", state_dbg, 2);
      tick();
      chk("halt_state", {state_dbg, halted, fault}, {3'd6, 2'b10});
      chk("halt_count", instr_count, 9);
      chk("halt_count_w2", b_instr_count, 3);
      start = 1'b1; tick(); start = 1'b0;
      chk("halt_sticky", state_dbg, 6);

      // Fetch timeout: 16 FETCH cycles without ack, then fault
      rst = 1'b1; #1;
      chk("rst2_halted", halted, 0);
      chk("rst2_count", instr_count, 0);
      rst = 1'b0; #1;
      start = 1'b1; tick(); start = 1'b0;
      for (int i = 0; i < 16; i++) begin
         chk("tmo_fetch_cycle", state_dbg, 1);
         tick();
      end
      chk("tmo_halt", {state_dbg, halted, fault, mem_req}, {3'd6, 3'b110});
      start = 1'b1; tick(); tick(); start = 1'b0;
      chk("tmo_start_ignored", {state_dbg, fault}, {3'd6, 1'b1});
      chk("tmo_count", instr_count, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
